// File: rtl/reg_chain_monitor.sv
// Checks a serial register chain by comparing its taps against a local shift-register model.
// Optional capture of the first failing cycle is built when REG_CHAIN_MON_CAPTURE_EN is defined.
module reg_chain_monitor #(
    parameter int DEPTH         = 15,
    parameter int CNT_W         = 16,
    parameter int SETTLE_CYCLES = 15,
    parameter int CHECK_CYCLES  = 256
) (
    input  logic             newCLK,
    input  logic             global_reset,
    input  logic             in_bit,
    input  logic [DEPTH-1:0] taps,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [3:0]       first_err_tap,
    output logic [CNT_W-1:0] first_err_cycle,
    output logic [DEPTH-1:0] cap_got,
    output logic [DEPTH-1:0] cap_exp
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CHECK,
        DONE
    } state_t;

    // The phase counter is sized for the longer phase, independent of CNT_W.
    localparam int PH_MAX = (SETTLE_CYCLES > CHECK_CYCLES) ? SETTLE_CYCLES : CHECK_CYCLES;
    localparam int PH_W   = (PH_MAX < 2) ? 1 : $clog2(PH_MAX);
    localparam logic [PH_W-1:0] SETTLE_LAST = PH_W'(SETTLE_CYCLES - 1);
    localparam logic [PH_W-1:0] CHECK_LAST  = PH_W'(CHECK_CYCLES - 1);

    state_t            state_q, state_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [DEPTH-1:0]  model;
    logic [DEPTH-1:0]  mis;
    logic [3:0]        low_tap;
    logic              start_ok;
    logic              hit;
    logic              first_hit;
    logic [CNT_W-1:0]  err_d;

    generate
        if (DEPTH == 1) begin : g_model_bit
            always_ff @(posedge newCLK) begin
                if (global_reset) model <= '0;
                else              model <= in_bit;
            end
        end else begin : g_model_shift
            // NOTE: sequential state uses <= so every register samples pre-edge values.
            always_ff @(posedge newCLK) begin
                if (global_reset) model <= '0;
                else              model <= {model[DEPTH-2:0], in_bit};
            end
        end
    endgenerate

    // Lowest mismatching tap wins: scan from the top so the last write is the lowest index.
    always_comb begin
        mis     = taps ^ model;
        low_tap = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (mis[k]) low_tap = 4'(k + 1);
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        start_ok = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = SETTLE;
                    phase_d  = '0;
                    start_ok = 1'b1;
                end
            end
            SETTLE: begin
                if (phase_q == SETTLE_LAST) begin
                    state_d = CHECK;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            CHECK: begin
                if (phase_q == CHECK_LAST) begin
                    state_d = DONE;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                phase_d = '0;
            end
        endcase
    end

    always_comb begin
        hit       = (state_q == CHECK) && (mis != '0);
        first_hit = hit && (first_err_tap == '0);
        err_d     = err_count;
        if (start_ok) begin
            err_d = '0;
        end else if (hit && (err_count != '1)) begin
            err_d = err_count + 1'b1;
        end
    end

    always_ff @(posedge newCLK) begin
        if (global_reset) begin
            state_q         <= IDLE;
            phase_q         <= '0;
            err_count       <= '0;
            first_err_tap   <= '0;
            first_err_cycle <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            err_count <= err_d;
            busy      <= (state_d == SETTLE) || (state_d == CHECK);
            done      <= (state_d == DONE);
            pass      <= (state_d == DONE) && (err_d == '0);
            if (start_ok) begin
                first_err_tap   <= '0;
                first_err_cycle <= '0;
            end else if (first_hit) begin
                first_err_tap   <= low_tap;
                first_err_cycle <= CNT_W'(phase_q);
            end
        end
    end

`ifdef REG_CHAIN_MON_CAPTURE_EN
    always_ff @(posedge newCLK) begin
        if (global_reset || start_ok) begin
            cap_got <= '0;
            cap_exp <= '0;
        end else if (first_hit) begin
            cap_got <= taps;
            cap_exp <= model;
        end
    end
`else
    assign cap_got = '0;
    assign cap_exp = '0;
`endif

endmodule

// File: tb/tb_reg_chain_monitor.sv
// Self-checking bench for reg_chain_monitor: directed step table, hand-written corner sequences,
// and a per-cycle reference built from the in_bit history and run-elapsed arithmetic.
module tb_reg_chain_monitor;

    localparam int S0 = 15, C0 = 256, W0 = 16;
    localparam int S1 = 15, C1 = 40,  W1 = 4;

    logic        clk;
    logic        global_reset;
    logic        in_bit;
    logic        start0, start1;
    logic [14:0] taps0, taps1;

    logic        busy0, done0, pass0;
    logic [15:0] err0, fcyc0;
    logic [3:0]  ftap0;
    logic [14:0] cg0, ce0;

    logic        busy1, done1, pass1;
    logic [3:0]  err1, fcyc1;
    logic [3:0]  ftap1;
    logic [14:0] cg1, ce1;

    reg_chain_monitor #(.DEPTH(15), .CNT_W(W0), .SETTLE_CYCLES(S0), .CHECK_CYCLES(C0)) dut (
        .newCLK(clk), .global_reset(global_reset), .in_bit(in_bit), .taps(taps0), .start(start0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .first_err_tap(ftap0),
        .first_err_cycle(fcyc0), .cap_got(cg0), .cap_exp(ce0)
    );

    reg_chain_monitor #(.DEPTH(15), .CNT_W(W1), .SETTLE_CYCLES(S1), .CHECK_CYCLES(C1)) dut_sat (
        .newCLK(clk), .global_reset(global_reset), .in_bit(in_bit), .taps(taps1), .start(start1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .first_err_tap(ftap1),
        .first_err_cycle(fcyc1), .cap_got(cg1), .cap_exp(ce1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          running;
        bit          done;
        int          elapsed;
        int          err;
        int          ftap;
        int          fcyc;
        logic [14:0] cg;
        logic [14:0] ce;
    } ref_t;

    typedef struct {
        bit          rst;
        bit          st;
        int          n;
        int          lo;
        int          hi;
        logic [14:0] mask;
        bit          busy;
        bit          done;
        bit          pass;
        int          err;
        int          tap;
        int          fcyc;
    } step_t;

    int   checks = 0;
    int   errors = 0;
    ref_t r0, r1;
    bit   hist[$];
    int   f_lo = -1, f_hi = -1;
    logic [14:0] f_mask = '0;
    bit   inv1 = 1'b0;
    step_t tbl[8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Expected run behaviour from elapsed edges since the accepted start.
    task automatic ref_step(inout ref_t r, input bit st, input logic [14:0] t, input logic [14:0] e,
                            input int s, input int c, input int maxc);
        logic [14:0] m;
        if (!r.running) begin
            if (st) begin
                r = '{default: 0};
                r.running = 1'b1;
            end
        end else begin
            r.elapsed++;
            if (r.elapsed > s && r.elapsed <= s + c) begin
                m = t ^ e;
                if (m != 0) begin
                    if (r.err < maxc) r.err++;
                    if (r.ftap == 0) begin
                        for (int k = 14; k >= 0; k--) if (m[k]) r.ftap = k + 1;
                        r.fcyc = r.elapsed - s - 1;
                        r.cg   = t;
                        r.ce   = e;
                    end
                end
            end
            if (r.elapsed == s + c) begin
                r.running = 1'b0;
                r.done    = 1'b1;
            end
        end
    endtask

    task automatic compare_all();
        logic [14:0] xg0, xe0, xg1, xe1;
`ifdef REG_CHAIN_MON_CAPTURE_EN
        xg0 = r0.cg; xe0 = r0.ce; xg1 = r1.cg; xe1 = r1.ce;
`else
        xg0 = '0; xe0 = '0; xg1 = '0; xe1 = '0;
`endif
        check("d0.busy", busy0, r0.running);
        check("d0.done", done0, r0.done);
        check("d0.pass", pass0, r0.done && r0.err == 0);
        check("d0.err_count", err0, r0.err);
        check("d0.first_err_tap", ftap0, r0.ftap);
        check("d0.first_err_cycle", fcyc0, r0.fcyc & 16'hffff);
        check("d0.cap_got", cg0, xg0);
        check("d0.cap_exp", ce0, xe0);
        check("d1.busy", busy1, r1.running);
        check("d1.done", done1, r1.done);
        check("d1.pass", pass1, r1.done && r1.err == 0);
        check("d1.err_count", err1, r1.err);
        check("d1.first_err_tap", ftap1, r1.ftap);
        check("d1.first_err_cycle", fcyc1, r1.fcyc & 15);
        check("d1.cap_got", cg1, xg1);
        check("d1.cap_exp", ce1, xe1);
    endtask

    // One clock: drive chain-consistent taps (plus any forced corruption), then check all outputs.
    task automatic tick(input bit rst, input bit st0, input bit st1);
        logic [14:0] e;
        logic [14:0] m0;
        int nx, idx;
        for (int k = 0; k < 15; k++) e[k] = hist[k];
        m0 = '0;
        if (r0.running) begin
            nx = r0.elapsed + 1;
            if (nx > S0 && nx <= S0 + C0) begin
                idx = nx - S0 - 1;
                if (idx >= f_lo && idx <= f_hi) m0 = f_mask;
            end
        end
        global_reset = rst;
        start0       = st0;
        start1       = st1;
        in_bit       = 1'($urandom);
        taps0        = e ^ m0;
        taps1        = inv1 ? ~e : e;
        @(posedge clk);
        if (rst) begin
            r0 = '{default: 0};
            r1 = '{default: 0};
            for (int k = 0; k < 15; k++) hist[k] = 1'b0;
        end else begin
            ref_step(r0, st0, taps0, e, S0, C0, (1 << W0) - 1);
            ref_step(r1, st1, taps1, e, S1, C1, (1 << W1) - 1);
            hist.push_front(in_bit);
            void'(hist.pop_back());
        end
        #1;
        compare_all();
    endtask

    initial begin
        global_reset = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        in_bit = 1'b0;
        taps0  = '0;
        taps1  = '0;
        for (int k = 0; k < 15; k++) hist.push_back(1'b0);
        r0 = '{default: 0};
        r1 = '{default: 0};

        //          rst st  n    lo  hi  mask      busy done pass err tap fcyc
        tbl[0] = '{1, 0, 1,   -1, -1, 15'h0000, 0, 0, 0, 0, 0, 0};
        tbl[1] = '{0, 0, 20,  -1, -1, 15'h0000, 0, 0, 0, 0, 0, 0};
        tbl[2] = '{0, 1, 271, -1, -1, 15'h0000, 1, 0, 0, 0, 0, 0};
        tbl[3] = '{0, 0, 1,   -1, -1, 15'h0000, 0, 1, 1, 0, 0, 0};
        tbl[4] = '{0, 1, 272, 10, 12, 15'h0010, 0, 1, 0, 3, 5, 10};
        tbl[5] = '{0, 0, 5,   10, 12, 15'h0010, 0, 1, 0, 3, 5, 10};
        tbl[6] = '{0, 1, 1,   -1, -1, 15'h0000, 1, 0, 0, 0, 0, 0};
        tbl[7] = '{0, 0, 271, -1, -1, 15'h0000, 0, 1, 1, 0, 0, 0};

        for (int i = 0; i < 8; i++) begin
            f_lo   = tbl[i].lo;
            f_hi   = tbl[i].hi;
            f_mask = tbl[i].mask;
            tick(tbl[i].rst, tbl[i].st, 1'b0);
            for (int c = 1; c < tbl[i].n; c++) tick(1'b0, 1'b0, 1'b0);
            check($sformatf("step%0d.busy", i), busy0, tbl[i].busy);
            check($sformatf("step%0d.done", i), done0, tbl[i].done);
            check($sformatf("step%0d.pass", i), pass0, tbl[i].pass);
            check($sformatf("step%0d.err_count", i), err0, tbl[i].err);
            check($sformatf("step%0d.first_err_tap", i), ftap0, tbl[i].tap);
            check($sformatf("step%0d.first_err_cycle", i), fcyc0, tbl[i].fcyc);
            if (tbl[i].mask != 0) begin
`ifdef REG_CHAIN_MON_CAPTURE_EN
                check($sformatf("step%0d.cap_xor", i), cg0 ^ ce0, tbl[i].mask);
`else
                check($sformatf("step%0d.cap_xor", i), cg0 ^ ce0, 0);
`endif
            end
        end
        f_lo = -1; f_hi = -1; f_mask = '0;

        // Start pulses during SETTLE and CHECK must not stretch or restart the window.
        tick(1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 271; i++) begin
            tick(1'b0, (i == 5) || (i % 50 == 0), 1'b0);
            if (i == 270) check("ign.busy_at_270", busy0, 1);
        end
        check("ign.done", done0, 1);
        check("ign.pass", pass0, 1);

        // Reset landing on CHECK cycle 100 together with start discards the partial result.
        f_lo = 50; f_hi = 60; f_mask = 15'h0001;
        tick(1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 115; i++) tick(1'b0, 1'b0, 1'b0);
        check("rst.pre_err", err0, 11);
        check("rst.pre_tap", ftap0, 1);
        tick(1'b1, 1'b1, 1'b0);
        check("rst.busy", busy0, 0);
        check("rst.done", done0, 0);
        check("rst.err", err0, 0);
        check("rst.tap", ftap0, 0);
        f_lo = -1; f_hi = -1; f_mask = '0;
        tick(1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 271; i++) tick(1'b0, 1'b0, 1'b0);
        check("rst.rerun_done", done0, 1);
        check("rst.rerun_pass", pass0, 1);

        // Narrow counter: every CHECK cycle mismatches, so err_count must stop at 15.
        inv1 = 1'b1;
        tick(1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= S1 + C1; i++) tick(1'b0, 1'b0, 1'b0);
        check("sat.done", done1, 1);
        check("sat.err_count", err1, 15);
        check("sat.first_err_tap", ftap1, 1);
        check("sat.pass", pass1, 0);
        inv1 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
